// File: rtl/coprocessor0.sv
// Coprocessor 0: STATUS/CAUSE/EPC/EHBR registers, one external interrupt
// line and ERET handling. A two-state FSM (idle / in service) redirects the PC
// to EHBR on an interrupt take and back to EPC on ERET.
// Optional: define CP0_IRQ_SYNC_EN to pass ir_in through a 2-flop synchronizer.
module coprocessor0 #(
  parameter logic [31:0] EHBR_RESET = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  cp_oper,
  input  logic [4:0]  addr_r,
  output logic [31:0] data_r,
  input  logic [4:0]  addr_w,
  input  logic [31:0] data_w,
  input  logic        ir_en,
  input  logic        ir_in,
  input  logic [31:0] ret_addr,
  output logic        jump_en,
  output logic [31:0] jump_addr
);

  localparam logic [4:0] AddrStatus = 5'd12;
  localparam logic [4:0] AddrCause  = 5'd13;
  localparam logic [4:0] AddrEpc    = 5'd14;
  localparam logic [4:0] AddrEhbr   = 5'd25;

  typedef enum logic [0:0] {StIdle, StService} state_t;

  state_t      state_q, state_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] ehbr_q, ehbr_d;
  logic        ir_prev_q;
  logic        ir_s;
  logic        irq_edge;
  logic        mtc0, eret, take;
  logic [31:0] wr_masked;

`ifdef CP0_IRQ_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for the asynchronous interrupt line.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], ir_in};
  end
  assign ir_s = sync_q[1];
`else
  assign ir_s = ir_in;
`endif

  // Edge detector keeps sampling while en=0 so no rising edge is lost.
  always_ff @(posedge clk) begin
    if (rst) ir_prev_q <= 1'b0;
    else     ir_prev_q <= ir_s;
  end

  assign irq_edge = ir_s & ~ir_prev_q;
  assign mtc0     = en & (cp_oper == 2'd1);
  assign eret     = en & (cp_oper == 2'd2);
  // ERET has priority; the take waits for a later cycle.
  assign take     = (state_q == StIdle) & pending_q & ie_q & ir_en & en & ~eret;

  // Write data reduced to the implemented bits of the target register.
  always_comb begin
    wr_masked = 32'h0;
    unique case (addr_w)
      AddrStatus: wr_masked = {31'h0, data_w[0]};
      AddrCause:  wr_masked = {23'h0, data_w[8], 8'h0};
      AddrEpc:    wr_masked = data_w;
      AddrEhbr:   wr_masked = data_w;
      default:    wr_masked = 32'h0;
    endcase
  end

  // Read port with same-cycle MTC0 bypass.
  always_comb begin
    data_r = 32'h0;
    if (mtc0 && (addr_w == addr_r)) begin
      data_r = wr_masked;
    end else begin
      unique case (addr_r)
        AddrStatus: data_r = {31'h0, ie_q};
        AddrCause:  data_r = {23'h0, pending_q, 8'h0};
        AddrEpc:    data_r = epc_q;
        AddrEhbr:   data_r = ehbr_q;
        default:    data_r = 32'h0;
      endcase
    end
  end

  // PC redirect: ERET to EPC, take to EHBR; forced off in reset.
  always_comb begin
    jump_en   = 1'b0;
    jump_addr = 32'h0;
    if (!rst) begin
      if (eret) begin
        jump_en   = 1'b1;
        jump_addr = epc_q;
      end else if (take) begin
        jump_en   = 1'b1;
        jump_addr = ehbr_q;
      end
    end
  end

  // Next-state logic: take overrides MTC0 to EPC/STATUS, edge overrides CAUSE write.
  always_comb begin
    state_d   = state_q;
    ie_d      = ie_q;
    pending_d = pending_q;
    epc_d     = epc_q;
    ehbr_d    = ehbr_q;
    if (mtc0) begin
      unique case (addr_w)
        AddrStatus: ie_d      = data_w[0];
        AddrCause:  pending_d = data_w[8];
        AddrEpc:    epc_d     = data_w;
        AddrEhbr:   ehbr_d    = data_w;
        default:    ;
      endcase
    end
    if (take) begin
      epc_d     = ret_addr;
      ie_d      = 1'b0;
      pending_d = 1'b0;
      state_d   = StService;
    end
    if (eret) begin
      ie_d    = 1'b1;
      state_d = StIdle;
    end
    if (irq_edge) pending_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
      epc_q     <= 32'h0;
      ehbr_q    <= EHBR_RESET;
    end else begin
      state_q   <= state_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
      epc_q     <= epc_d;
      ehbr_q    <= ehbr_d;
    end
  end

endmodule

// File: doc/coprocessor0.md
COPROCESSOR0 -- requirements
Module: coprocessor0

Interface
REQ-001 SHALL provide parameter: EHBR_RESET, 32'h0000_0008, reset value of the exception handler base register.
REQ-002 SHALL provide port: clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL provide port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide port: en  input  1  stage enable (debug freeze when 0).
REQ-005 SHALL provide port: cp_oper  input  2  0=none, 1=store (MTC0), 2=ERET, 3=reserved (treated as none).
REQ-006 SHALL provide port: addr_r  input  5  CP0 register read address (MFC0).
REQ-007 SHALL provide port: data_r  output  32  CP0 read data.
REQ-008 SHALL provide port: addr_w  input  5  CP0 register write address.
REQ-009 SHALL provide port: data_w  input  32  CP0 write data.
REQ-010 SHALL provide port: ir_en  input  1  global interrupt permit from the controller.
REQ-011 SHALL provide port: ir_in  input  1  external interrupt request, level, asynchronous to clk.
REQ-012 SHALL provide port: ret_addr  input  32  PC to resume at after the handler.
REQ-013 SHALL provide port: jump_en  output  1  redirect PC this cycle.
REQ-014 SHALL provide port: jump_addr  output  32  redirect target.

Function
REQ-015 SHALL implement registers: STATUS (addr 12, bit0 = IE, other bits read 0), CAUSE (addr 13, bit8 = IP pending, other bits 0), EPC (addr 14), EHBR (addr 25); every other address reads 0 and ignores writes.
REQ-016 SHALL drive data_r combinationally from addr_r; when cp_oper=1, en=1 and addr_w==addr_r, data_r SHALL bypass data_w (masked to implemented bits).
REQ-017 SHALL set pending on a detected 0->1 edge of the (optionally synchronized) ir_in; a level held high SHALL set pending only once.
REQ-018 SHALL implement an FSM with states IDLE and SERVICE.
REQ-019 SHALL take the interrupt when state=IDLE, pending=1, IE=1, ir_en=1, en=1 and cp_oper!=2; in that cycle jump_en=1 and jump_addr=EHBR (combinational).
REQ-020 SHALL, on the edge ending a take cycle: EPC<=ret_addr, IE<=0, pending<=0, state<=SERVICE.
REQ-021 SHALL, when cp_oper=2 and en=1 (any state), assert jump_en=1 with jump_addr=EPC in the same cycle; on the edge: IE<=1, state<=IDLE.
REQ-022 SHALL give ERET priority over a take in the same cycle; pending SHALL remain set and the take SHALL occur no earlier than the next cycle.
REQ-023 SHALL give a take priority over a same-cycle MTC0 to EPC or STATUS (EPC gets ret_addr, IE gets 0); MTC0 to other registers completes normally.
REQ-024 SHALL let MTC0 to CAUSE clear or set pending (software acknowledge); an edge arriving in the same cycle SHALL win and leave pending=1.
REQ-025 SHALL, when en=0, hold all state and force jump_en=0; edge detection SHALL still sample ir_in so no edge is lost.
REQ-026 SHALL drive jump_addr=0 whenever jump_en=0.

Reset
REQ-027 SHALL on rst: STATUS=0 (IE=0), CAUSE=0, EPC=0, EHBR=EHBR_RESET, state=IDLE, edge/sync flops=0; jump_en=0 and jump_addr=0 during rst.
REQ-028 SHALL discard a pending interrupt or in-progress service on rst; rst SHALL override all other inputs.

Configuration
REQ-029 SHALL support macro CP0_IRQ_SYNC_EN: defined -> ir_in passes a 2-flop synchronizer before the edge detector (pending sets 3 edges after ir_in rises); undefined -> ir_in feeds the edge detector directly (pending sets 1 edge after ir_in rises).

Verification
REQ-030 SHALL verify: IE=1 via MTC0 12 data 1, ir_en=1, ret_addr=0x40, ir_in rises -> one-cycle jump_en, jump_addr=0x08, then EPC reads 0x40, IE=0, pending=0.
REQ-031 SHALL verify: in SERVICE, cp_oper=2 -> same-cycle jump_en, jump_addr=0x40; next cycle STATUS reads 1, state IDLE.
REQ-032 SHALL verify: ir_in held high 20 cycles -> exactly one take; with IE=0, an edge leaves CAUSE reading 0x100 and jump_en stays 0.
REQ-033 SHALL verify: ERET and a take condition in the same cycle -> jump_addr=EPC; take follows one cycle later to EHBR.
REQ-034 SHALL verify: MTC0 addr 14 data 0x1234 with addr_r=14 -> data_r=0x1234 in the same cycle; addr 7 write then read -> 0.
REQ-035 SHALL verify: en=0 during an ir_in edge -> no jump_en; take occurs on the first cycle en=1; with and without CP0_IRQ_SYNC_EN, pending latency is 3 and 1 edges.
